// File: rtl/unary_digit_collector_if.sv
// Result handshake between the unary digit collector and the next stage:
// the collector drives digit/carry/overflow qualified by valid, and the next stage answers with ready.
interface unary_digit_collector_if;
    logic       valid;
    logic       ready;
    logic [3:0] digit;
    logic       carry;
    logic       overflow;

    modport master (
        output valid,
        output digit,
        output carry,
        output overflow,
        input  ready
    );

    modport slave (
        input  valid,
        input  digit,
        input  carry,
        input  overflow,
        output ready
    );
endinterface

// File: rtl/unary_digit_collector.sv
// Counts the write-phase ones of the serial unary adder output into a 4-bit digit and
// presents digit, carry and overflow to the next stage over a valid/ready handshake.
module unary_digit_collector #(
    parameter logic [3:0] DIGIT_MAX = 4'd9
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic                            read_or_write_i,
    input  logic                            din_i,
    input  logic                            cin_i,
    unary_digit_collector_if.master         res_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       seen_one_q, seen_one_d;
    logic       carry_pend_q, carry_pend_d;
    logic       sat_q, sat_d;
    logic       valid_q, valid_d;
    logic [3:0] digit_q, digit_d;
    logic       carry_out_q, carry_out_d;
    logic       overflow_q, overflow_d;
    logic       end_s;

    // A digit ends at the first zero after a one, or when the write phase closes.
    assign end_s = (seen_one_q && !din_i) || !read_or_write_i;

    // State register with synchronous reset; reset discards any partial digit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= 4'd0;
            seen_one_q   <= 1'b0;
            carry_pend_q <= 1'b0;
            sat_q        <= 1'b0;
            valid_q      <= 1'b0;
            digit_q      <= 4'd0;
            carry_out_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            seen_one_q   <= seen_one_d;
            carry_pend_q <= carry_pend_d;
            sat_q        <= sat_d;
            valid_q      <= valid_d;
            digit_q      <= digit_d;
            carry_out_q  <= carry_out_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state and output logic; en gates sampling, but the HOLD handshake is ungated.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        seen_one_d   = seen_one_q;
        carry_pend_d = carry_pend_q;
        sat_d        = sat_q;
        valid_d      = valid_q;
        digit_d      = digit_q;
        carry_out_d  = carry_out_q;
        overflow_d   = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i && read_or_write_i) begin
                    state_d    = ST_COLLECT;
                    acc_d      = {3'b000, din_i};
                    seen_one_d = din_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (en_i && end_s) begin
                    digit_d      = acc_q;
                    carry_out_d  = carry_pend_q;
                    overflow_d   = (acc_q > DIGIT_MAX) | sat_q;
                    valid_d      = 1'b1;
                    carry_pend_d = 1'b0;
                    state_d      = ST_HOLD;
                end else if (en_i && din_i) begin
                    seen_one_d = 1'b1;
                    if (acc_q == 4'd15) begin
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_q + 4'd1;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (valid_q && res_o.ready) begin
                    valid_d    = 1'b0;
                    acc_d      = 4'd0;
                    seen_one_d = 1'b0;
                    sat_d      = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A carry arriving on the closing cycle belongs to the next digit.
        if (en_i && cin_i) begin
            carry_pend_d = 1'b1;
        end else begin
            carry_pend_d = carry_pend_d;
        end
    end

    assign res_o.valid    = valid_q;
    assign res_o.digit    = digit_q;
    assign res_o.carry    = carry_out_q;
    assign res_o.overflow = overflow_q;

endmodule

// File: tb/tb_unary_digit_collector.sv
// Directed self-checking bench for unary_digit_collector with hand-computed expectations.
module tb_unary_digit_collector;

    logic clk;
    logic rst;
    logic en;
    logic read_or_write;
    logic din;
    logic cin;

    int n_checks = 0;
    int n_fail   = 0;

    unary_digit_collector_if res_if ();

    unary_digit_collector #(.DIGIT_MAX(4'd9)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .read_or_write_i (read_or_write),
        .din_i           (din),
        .cin_i           (cin),
        .res_o           (res_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply one sample, clock it in, and settle 1 time unit past the edge.
    task automatic drive(input logic d, input logic rw, input logic e, input logic c);
        din           = d;
        read_or_write = rw;
        en            = e;
        cin           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [3:0] dg, input logic cy, input logic ov);
        check_eq({tag, ".valid"}, {31'd0, res_if.valid}, 32'd1);
        check_eq({tag, ".digit"}, {28'd0, res_if.digit}, {28'd0, dg});
        check_eq({tag, ".carry"}, {31'd0, res_if.carry}, {31'd0, cy});
        check_eq({tag, ".ovf"},   {31'd0, res_if.overflow}, {31'd0, ov});
    endtask

    // Leading zero, n ones, terminating zero: valid is expected right after.
    task automatic write_digit(input int n);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; read_or_write = 1'b0; din = 1'b0; cin = 1'b0;
        res_if.ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst.valid", {31'd0, res_if.valid}, 32'd0);
        check_eq("rst.digit", {28'd0, res_if.digit}, 32'd0);
        check_eq("rst.carry", {31'd0, res_if.carry}, 32'd0);
        check_eq("rst.ovf",   {31'd0, res_if.overflow}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Basic count: 0,1,1,1,0
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("basic.early", {31'd0, res_if.valid}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_result("basic", 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("basic.drop", {31'd0, res_if.valid}, 32'd0);

        // Carry captured in read phase, attached to next digit only
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        write_digit(4);
        check_result("carry", 4'd4, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        write_digit(2);
        check_result("nocarry", 4'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Zero digit terminated by end of write phase
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("zero.early", {31'd0, res_if.valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_result("zero", 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("zero.drop", {31'd0, res_if.valid}, 32'd0);

        // Back-pressure: result 5 held while din toggles
        res_if.ready = 1'b0;
        write_digit(5);
        check_result("bp", 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(i[0], 1'b1, 1'b1, 1'b0);
            check_result("bp.hold", 4'd5, 1'b0, 1'b0);
        end
        res_if.ready = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("bp.drop", {31'd0, res_if.valid}, 32'd0);
        write_digit(2);
        check_result("bp.next", 4'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation and DIGIT_MAX boundary
        write_digit(17);
        check_result("sat", 4'd15, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        write_digit(10);
        check_result("ten", 4'd10, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        write_digit(9);
        check_result("nine", 4'd9, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Enable gating: disabled ones and a disabled zero are ignored
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("en.frozen", {31'd0, res_if.valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_result("en", 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-collect with a pending carry
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        check_eq("mrst.valid", {31'd0, res_if.valid}, 32'd0);
        check_eq("mrst.digit", {28'd0, res_if.digit}, 32'd0);
        check_eq("mrst.carry", {31'd0, res_if.carry}, 32'd0);
        check_eq("mrst.ovf",   {31'd0, res_if.overflow}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("mrst.novalid", {31'd0, res_if.valid}, 32'd0);
        write_digit(1);
        check_result("mrst.next", 4'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unary_digit_collector.md
# unary_digit_collector

Downstream stage of the serial unary adder. It consumes the adder's serial unary result (`dout`) and carry pulse (`C`), and counts the write-phase ones into a 4-bit digit. It then presents digit plus carry to the next stage over a valid/ready handshake. It runs on the same `en` / `read_or_write` phase signals as the adder and is wired directly to its outputs.

## Interface
- `DIGIT_MAX`, default 9: largest legal digit value; a collected count above it flags `overflow`.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: sample enable, same signal that drives the adder.
- `read_or_write`  in  1: phase indicator, 0 = adder read phase, 1 = adder write phase.
- `din`  in  1: serial unary data, connected to the adder's `dout`.
- `cin`  in  1: carry pulse, connected to the adder's `C`.
- `ready`  in  1: downstream accepts the result.
- `valid`  out  1: result available.
- `digit_out`  out  4: collected count, 0..15.
- `carry_out`  out  1: carry associated with this digit.
- `overflow`  out  1: `digit_out` > `DIGIT_MAX` or the accumulator saturated.

## Operation
- Internal state:
  - `acc[3:0]`
  - `seen_one`
  - `carry_pend`
  - FSM with states IDLE, COLLECT, HOLD.
- `en` gates all sampling of `din`, `cin` and `read_or_write`. When `en`=0, `acc`, `seen_one`, `carry_pend` and the FSM state are frozen. The HOLD handshake still completes.
- Carry capture, in any state:
  - `en && cin` sets `carry_pend`.
  - `carry_pend` is cleared on the COLLECT→HOLD transition.
  - If `cin` is asserted in that same cycle, set wins and the carry is kept for the next digit.
- IDLE:
  - On `en && read_or_write`: go to COLLECT.
  - In that cycle, `acc` becomes `din` (0 or 1) and `seen_one` becomes `din`.
- COLLECT, on each `en` cycle:
  - End condition: `(seen_one && !din) || !read_or_write`. If it holds:
    - `digit_out` <= `acc`
    - `carry_out` <= `carry_pend`
    - `overflow` <= (`acc` > `DIGIT_MAX`) | saturation flag
    - `valid` <= 1
    - go to HOLD
    - `din` is not added in this cycle.
  - Otherwise, if `din`=1:
    - `acc` <= `acc` + 1, saturating at 15.
    - An increment attempted at 15 sets the internal saturation flag.
    - `seen_one` <= 1.
  - Leading zeros before the first one are ignored. The adder's first write-phase `dout` is always 0.
- HOLD:
  - `valid`, `digit_out`, `carry_out` and `overflow` are held stable.
  - `din` is ignored.
  - On `valid && ready`: `valid` <= 0, `acc`, `seen_one` and the saturation flag are cleared, go to IDLE.
  - A new write phase is recognised only from IDLE, so at earliest the cycle after the handshake.
- Arithmetic:
  - 4-bit unsigned, no wrap-around.
  - 15 is the ceiling.

## Timing
- Reset (`rst`=1 at an edge), applies in any state including mid-COLLECT, with no partial result emitted:
  - `valid`=0, `digit_out`=0, `carry_out`=0, `overflow`=0
  - `acc`=0, `seen_one`=0, `carry_pend`=0, saturation flag 0
  - state IDLE
- Latency: `valid` rises on the edge following the terminating sample, i.e. 1 cycle after the first `din`=0 that follows the last one.
- Zero digit: `valid` rises 1 cycle after the sample with `read_or_write`=0 in COLLECT.
- Handshake: transfer occurs on an edge where `valid`=1 and `ready`=1, and `valid` is 0 after that edge.
  - `ready` may be held high permanently, giving single-cycle `valid` pulses.
  - `ready` has no effect while `valid`=0.
- Throughput: at most one digit per write phase. The minimum gap from transfer to the next COLLECT entry is 1 cycle.

## Test plan
1. Basic count:
   - Stimulus: `read_or_write`=1, `en`=1, `din` = 0,1,1,1,0, `ready`=1.
   - Response: `valid` pulses 1 cycle after the trailing 0, with `digit_out`=3, `carry_out`=0, `overflow`=0.
2. Carry:
   - Stimulus: `cin`=1 for one cycle during `read_or_write`=0, then a write phase with `din` = 0,1,1,1,1,0.
   - Response: `digit_out`=4, `carry_out`=1. The next digit without `cin` shows `carry_out`=0.
3. Zero result:
   - Stimulus: write phase with `din`=0 for 3 cycles, then `read_or_write`=0.
   - Response: `digit_out`=0 and `valid`=1, 1 cycle later.
4. Back-pressure:
   - Stimulus: result 5 with `ready`=0 for 6 cycles, `din` toggling during HOLD.
   - Response: outputs frozen at 5. `ready`=1 causes `valid` to drop the next cycle, and the following write phase collects from 0.
5. Saturation:
   - Stimulus: 17 consecutive `din`=1.
   - Response: `digit_out`=15, `overflow`=1.
   - Also: 10 ones with `DIGIT_MAX`=9 gives `digit_out`=10, `overflow`=1.
6. Enable and reset:
   - Stimulus: in COLLECT after 2 ones, `en`=0 for 3 cycles with `din`=1.
   - Response: `acc` stays 2 and the final digit counts only enabled ones.
   - Stimulus: `rst`=1 after 2 ones.
   - Response: all outputs 0 next cycle, no `valid`.
